// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs format/opcode/register/immediate fields into a
// 32-bit word tagged with a sequential byte address, through a two-stage valid/ready pipe.
module instr_encoder #(
  parameter int AW   = 12,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [31:0]     in_imm,
  input  logic            addr_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [AW-1:0]   out_addr,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          a_valid;
  fields_t       a;
  logic          b_valid;
  logic          b_adv;
  logic          a_adv;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] addr_base;
  logic [31:0]   enc_instr;
  logic          enc_err;

  assign b_adv     = !b_valid || out_ready;
  assign a_adv     = !a_valid || b_adv;
  assign in_ready  = a_adv;
  assign out_valid = b_valid;
  assign addr_base = addr_clr ? '0 : addr_cnt;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b1;
    case (a.fmt)
      FMT_R: begin
        enc_instr = {a.funct7, a.rs2, a.rs1, a.funct3, a.rd, a.opcode};
        enc_err   = 1'b0;
      end
      FMT_I: begin
        enc_instr = {a.imm[11:0], a.rs1, a.funct3, a.rd, a.opcode};
        enc_err   = a.imm != {{20{a.imm[11]}}, a.imm[11:0]};
      end
      FMT_S: begin
        enc_instr = {a.imm[11:5], a.rs2, a.rs1, a.funct3, a.imm[4:0], a.opcode};
        enc_err   = a.imm != {{20{a.imm[11]}}, a.imm[11:0]};
      end
      FMT_B: begin
        enc_instr = {a.imm[12], a.imm[10:5], a.rs2, a.rs1, a.funct3,
                     a.imm[4:1], a.imm[11], a.opcode};
        // 13-bit signed range with bit 0 clear gives [-4096, 4094]
        enc_err   = a.imm[0] || (a.imm != {{19{a.imm[12]}}, a.imm[12:0]});
      end
      FMT_U: begin
        enc_instr = {a.imm[31:12], a.rd, a.opcode};
        enc_err   = |a.imm[11:0];
      end
      FMT_J: begin
        enc_instr = {a.imm[20], a.imm[10:1], a.imm[11], a.imm[19:12], a.rd, a.opcode};
        enc_err   = a.imm[0] || (a.imm != {{11{a.imm[20]}}, a.imm[20:0]});
      end
      default: ;
    endcase
  end

  // NOTE: stage-A field registers are pure datapath qualified by a_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (a_adv && in_valid) begin
      a <= '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
             funct3: in_funct3, funct7: in_funct7, imm: in_imm};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      addr_cnt  <= '0;
      err_count <= '0;
    end else begin
      if (a_adv) a_valid <= in_valid;

      if (b_adv) begin
        b_valid <= a_valid;
        if (a_valid) begin
          out_instr <= enc_instr;
          out_err   <= enc_err;
          out_addr  <= addr_base;
        end
      end

      // Counter wraps naturally modulo 2^AW; a clear in the same cycle restarts from 0.
      if (b_adv && a_valid) addr_cnt <= addr_base + AW'(4);
      else if (addr_clr)    addr_cnt <= '0;

      if (b_valid && out_ready && out_err && (err_count != {ERRW{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-bit address and 2-bit error counter so
// address wrap and counter saturation are reached within a short run.
module tb_instr_encoder;

  localparam int AW   = 4;
  localparam int ERRW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_fmt;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd, in_rs1, in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [31:0]     in_imm;
  logic            addr_clr;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [AW-1:0]   out_addr;
  logic            out_err;
  logic [ERRW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.AW(AW), .ERRW(ERRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_clr(addr_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr,
                           input logic [AW-1:0] addr, input logic err);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_addr"},  32'(out_addr), 32'(addr));
    check({tag, "_err"},   32'(out_err), 32'(err));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fmt    = '0;
    in_opcode = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_imm    = '0;
    addr_clr  = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err",   32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // I then S back-to-back
    set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    check("lat_not_yet", 32'(out_valid), 32'd0);
    set_in(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    in_valid = 1'b0;
    check_out("i_neg1", 32'hFFF0_0093, 4'd0, 1'b0);
    step();
    check_out("s_imm8", 32'h0020_A423, 4'd4, 1'b0);
    step();
    check("drain1", 32'(out_valid), 32'd0);

    // B, J, U streamed; U is the 5th word and wraps to address 0
    set_in(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    step();
    set_in(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    check_out("b_neg4", 32'hFE00_0EE3, 4'd8, 1'b0);
    set_in(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    in_valid = 1'b0;
    check_out("j_2048", 32'h0010_00EF, 4'd12, 1'b0);
    step();
    check_out("u_wrap", 32'h1234_52B7, 4'd0, 1'b0);
    step();
    check("errcnt_clean", 32'(err_count), 32'd0);

    // Error words
    set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    set_in(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    step();
    check_out("e_i2048", 32'h8000_0093, 4'd4, 1'b1);
    set_in(3'd7, 7'h33, 5'd3, 5'd3, 5'd3, 3'd7, 7'h7F, 32'd0);
    step();
    in_valid = 1'b0;
    check_out("e_b_odd", 32'h0000_0163, 4'd8, 1'b1);
    step();
    check_out("e_fmt7", 32'h0000_0013, 4'd12, 1'b1);
    step();
    check("errcnt_3", 32'(err_count), 32'd3);

    // Saturation of the 2-bit counter
    set_in(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    in_valid = 1'b0;
    step();
    check_out("e_fmt6", 32'h0000_0013, 4'd0, 1'b1);
    step();
    check("errcnt_sat", 32'(err_count), 32'd3);

    // addr_clr coinciding with a word entering stage B
    set_in(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF);
    step();
    addr_clr = 1'b1;
    set_in(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    addr_clr = 1'b0;
    in_valid = 1'b0;
    check_out("r_clr", 32'h4031_00B3, 4'd0, 1'b0);
    step();
    check_out("i_after_clr", 32'h0000_0013, 4'd4, 1'b0);
    step();

    // Backpressure: only two words fit
    out_ready = 1'b0;
    set_in(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    check("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    set_in(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2000);
    check("bp_rdy2", 32'(in_ready), 32'd1);
    step();
    set_in(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_3000);
    check("bp_rdy3", 32'(in_ready), 32'd0);
    step();
    step();
    check("bp_rdy_held", 32'(in_ready), 32'd0);
    check_out("bp_hold", 32'h0000_10B7, 4'd8, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_comb", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_out("bp_w2", 32'h0000_2137, 4'd12, 1'b0);
    step();
    check_out("bp_w3", 32'h0000_31B7, 4'd0, 1'b0);
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    set_in(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    step();
    set_in(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_errcnt", 32'(err_count), 32'd0);
    check("mid_rst_instr", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_empty", 32'(out_valid), 32'd0);
    set_in(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    in_valid = 1'b0;
    step();
    check_out("post_rst_word", 32'h0050_8113, 4'd0, 1'b0);
    step();
    check("post_rst_drain", 32'(out_valid), 32'd0);
    check("post_rst_errcnt", 32'(err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
